// File: rtl/opb_regbank_pkg.sv
// Shared types and map helpers for the OPB register bank.
// Holds FSM states, CTRL/STATUS bit positions and offset helpers.
package opb_regbank_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int STATUS_DB_BIT   = 24;

    function automatic logic [31:0] word_off(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr - base) >> 2;
    endfunction

    function automatic logic [31:0] ctrl_off(input int n);
        return 32'(n);
    endfunction

    function automatic logic [31:0] status_off(input int n);
        return 32'(n + 1);
    endfunction

endpackage

// File: rtl/opb_regbank_slave_if.sv
// OPB slave front end: window decode, transfer FSM, acks, read-data gating.
// Presents a one-cycle write strobe with latched offset/data/byte-enables.
module opb_regbank_slave_if
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR     = 32'h01003200,
    parameter logic [31:0] C_HIGHADDR     = 32'h010032FF,
    parameter int          NUM_REGS       = 8,
    parameter int          C_ERR_UNMAPPED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic        rnw,
    input  logic        select,
    input  logic [31:0] rdata,
    output logic        ack,
    output logic        err_ack,
    output logic [31:0] rd_data,
    output logic        wr_en,
    output logic [31:0] off,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data
);

    state_t state, state_nxt;
    logic   rnw_q;
    logic   hit;
    logic   mapped;

    assign hit    = select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign mapped = off < status_off(NUM_REGS) + 32'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: a dropped select in ACK aborts, WAIT blocks a second ack
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (hit) state_nxt = S_ACK;
            S_ACK:  state_nxt = select ? S_WAIT : S_IDLE;
            S_WAIT: if (!select) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs, read data forced to zero outside a read ack
    always_comb begin
        ack     = (state == S_ACK) && select;
        err_ack = ack && !mapped && (C_ERR_UNMAPPED != 0);
        rd_data = (ack && rnw_q) ? rdata : 32'd0;
        wr_en   = ack && !rnw_q;
    end

    // Capture the request when the transfer is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rnw_q   <= 1'b1;
            off     <= '0;
            wr_be   <= '0;
            wr_data <= '0;
        end else if (state == S_IDLE && hit) begin
            rnw_q   <= rnw;
            off     <= word_off(addr, C_BASEADDR);
            wr_be   <= be;
            wr_data <= wdata;
        end
    end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// PPC-writable register bank with shadow/active copies and atomic commit.
// Feeds Simulink user logic through active registers and load strobes.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR     = 32'h01003200,
    parameter logic [31:0] C_HIGHADDR     = 32'h010032FF,
    parameter int          NUM_REGS       = 8,
    parameter int          C_DOUBLE_BUF   = 1,
    parameter logic [31:0] C_RESET_VAL    = 32'h00000000,
    parameter int          C_ERR_UNMAPPED = 1
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [0:31]              OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:31]              OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:31]              Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    output logic [NUM_REGS*32-1:0]   user_data_out,
    output logic [NUM_REGS-1:0]      user_load,
    output logic                     user_commit
);

    logic [31:0]         rdata, rd_data, off, wr_data;
    logic [3:0]          wr_be;
    logic                wr_en;
    logic [31:0]         shadow     [NUM_REGS];
    logic [31:0]         active     [NUM_REGS];
    logic [31:0]         shadow_nxt [NUM_REGS];
    logic                auto_commit;
    logic [15:0]         commit_count;
    logic                reg_wr, ctrl_wr, commit;
    logic [NUM_REGS-1:0] load_nxt;
    logic                unused_seq;

    assign unused_seq = OPB_seqAddr;
    assign Sl_DBus    = rd_data;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    opb_regbank_slave_if #(
        .C_BASEADDR    (C_BASEADDR),
        .C_HIGHADDR    (C_HIGHADDR),
        .NUM_REGS      (NUM_REGS),
        .C_ERR_UNMAPPED(C_ERR_UNMAPPED)
    ) u_slave_if (
        .clk    (OPB_Clk),
        .rst    (OPB_Rst),
        .addr   (OPB_ABus),
        .be     (OPB_BE),
        .wdata  (OPB_DBus),
        .rnw    (OPB_RNW),
        .select (OPB_select),
        .rdata  (rdata),
        .ack    (Sl_xferAck),
        .err_ack(Sl_errAck),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .off    (off),
        .wr_be  (wr_be),
        .wr_data(wr_data)
    );

    // Write decode, byte-lane merge and commit/load decisions
    always_comb begin
        reg_wr  = wr_en && (off < 32'(NUM_REGS));
        ctrl_wr = wr_en && (off == ctrl_off(NUM_REGS));
        commit  = (ctrl_wr && wr_be[0] && wr_data[CTRL_COMMIT_BIT])
               || (reg_wr && auto_commit);
        for (int k = 0; k < NUM_REGS; k++) begin
            shadow_nxt[k] = shadow[k];
            if (reg_wr && off == 32'(k)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) shadow_nxt[k][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (C_DOUBLE_BUF != 0)
                load_nxt[k] = commit && (shadow_nxt[k] != active[k]);
            else
                load_nxt[k] = reg_wr && (off == 32'(k)) && (wr_be != 4'd0);
        end
    end

    // Read mux; user registers return the shadow copy
    always_comb begin
        rdata = 32'd0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (off == 32'(k)) rdata = shadow[k];
        end
        if (off == ctrl_off(NUM_REGS))
            rdata = {30'd0, auto_commit, 1'b0};
        if (off == status_off(NUM_REGS))
            rdata = {7'd0, (C_DOUBLE_BUF != 0), 8'(NUM_REGS), commit_count};
    end

    // Bank state: shadow, active, control and strobes
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow[k] <= C_RESET_VAL;
                active[k] <= C_RESET_VAL;
            end
            auto_commit  <= 1'b0;
            commit_count <= 16'd0;
            user_load    <= '0;
            user_commit  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow[k] <= shadow_nxt[k];
                if ((C_DOUBLE_BUF == 0) || commit) active[k] <= shadow_nxt[k];
            end
            if (ctrl_wr && wr_be[0]) auto_commit <= wr_data[CTRL_AUTO_BIT];
            if (commit) commit_count <= commit_count + 16'd1;
            user_load   <= load_nxt;
            user_commit <= commit;
        end
    end

    // Flatten active registers onto the user bus
    always_comb begin
        user_data_out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            user_data_out[32*k +: 32] = active[k];
        end
    end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for the OPB register bank.
// Read expectations go through a scoreboard queue popped on each ack.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE   = 32'h01003200;
    localparam logic [31:0] CTRL   = BASE + 32'd32;
    localparam logic [31:0] STATUS = BASE + 32'd36;
    localparam logic [31:0] UNMAP  = BASE + 32'h40;

    logic          OPB_Clk = 1'b0;
    logic          OPB_Rst;
    logic [0:31]   OPB_ABus;
    logic [0:3]    OPB_BE;
    logic [0:31]   OPB_DBus;
    logic          OPB_RNW;
    logic          OPB_select;
    logic          OPB_seqAddr;
    logic [0:31]   Sl_DBus;
    logic          Sl_xferAck;
    logic          Sl_errAck;
    logic          Sl_retry;
    logic          Sl_toutSup;
    logic [255:0]  user_data_out;
    logic [7:0]    user_load;
    logic          user_commit;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_q[$];

    opb_register_bank_ppc2simulink dut (
        .OPB_Clk      (OPB_Clk),
        .OPB_Rst      (OPB_Rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_out(user_data_out),
        .user_load    (user_load),
        .user_commit  (user_commit)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Single-beat transfer; returns one cycle after the ack edge
    task automatic bus(input logic [31:0] a, input logic rnw,
                       input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rd, output logic err);
        logic got;
        @(posedge OPB_Clk); #1;
        OPB_ABus = a; OPB_RNW = rnw; OPB_DBus = d; OPB_BE = be;
        OPB_select = 1'b1;
        rd = 32'd0; err = 1'b0; got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge OPB_Clk); #1;
            if (Sl_xferAck) begin
                got = 1'b1; rd = Sl_DBus; err = Sl_errAck;
            end
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL ack_timeout addr=%h got no ack want ack", a);
        end
        @(posedge OPB_Clk); #1;
        OPB_select = 1'b0; OPB_RNW = 1'b1; OPB_DBus = '0; OPB_ABus = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        logic [31:0] rd; logic err;
        bus(a, 1'b0, d, be, rd, err);
    endtask

    // Push expectation, read, pop and compare
    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] e);
        logic [31:0] rd, want; logic err;
        exp_q.push_back(e);
        bus(a, 1'b1, 32'd0, 4'hF, rd, err);
        want = exp_q.pop_front();
        compared++;
        if (rd !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", nm, rd, want);
        end
    endtask

    task automatic test_reset;
        OPB_Rst = 1'b1; OPB_select = 1'b0; OPB_RNW = 1'b1;
        OPB_ABus = '0; OPB_DBus = '0; OPB_BE = '0; OPB_seqAddr = 1'b0;
        repeat (3) @(posedge OPB_Clk);
        #1;
        compared++;
        if ({Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, Sl_DBus} !== 36'd0) begin
            mismatched++;
            $display("FAIL reset_sl: got %h want 0",
                     {Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, Sl_DBus});
        end
        compared++;
        if ({user_load, user_commit, user_data_out} !== 265'd0) begin
            mismatched++;
            $display("FAIL reset_user: got load=%h commit=%b want 0",
                     user_load, user_commit);
        end
        OPB_Rst = 1'b0;
        for (int k = 0; k < 8; k++) rd_chk("reset_reg", BASE + 32'(4*k), 32'd0);
        rd_chk("reset_ctrl", CTRL, 32'd0);
        rd_chk("reset_status", STATUS, 32'h01080000);
    endtask

    task automatic test_double_buffer;
        wr(BASE + 32'd8, 32'hDEADBEEF, 4'hF);
        rd_chk("db_readback", BASE + 32'd8, 32'hDEADBEEF);
        compared++;
        if (user_data_out[95:64] !== 32'd0) begin
            mismatched++;
            $display("FAIL db_active_hold: got %h want 0", user_data_out[95:64]);
        end
        wr(CTRL, 32'd1, 4'hF);
        compared++;
        if ({user_load, user_commit, user_data_out[95:64]} !== {8'h04, 1'b1, 32'hDEADBEEF}) begin
            mismatched++;
            $display("FAIL db_commit: got load=%h commit=%b r2=%h want 04 1 deadbeef",
                     user_load, user_commit, user_data_out[95:64]);
        end
        @(posedge OPB_Clk); #1;
        compared++;
        if ({user_load, user_commit} !== 9'd0) begin
            mismatched++;
            $display("FAIL db_pulse_width: got load=%h commit=%b want 0",
                     user_load, user_commit);
        end
        rd_chk("db_status", STATUS, 32'h01080001);
        rd_chk("db_ctrl_selfclear", CTRL, 32'd0);
    endtask

    task automatic test_byte_enable;
        wr(BASE + 32'd20, 32'hAAAAAAAA, 4'hF);
        wr(BASE + 32'd20, 32'h12345678, 4'b0011);
        rd_chk("be_low_half", BASE + 32'd20, 32'hAAAA5678);
        wr(BASE + 32'd20, 32'hFFFFFFFF, 4'b0000);
        rd_chk("be_none", BASE + 32'd20, 32'hAAAA5678);
        wr(BASE + 32'd20, 32'h11FFFFFF, 4'b1000);
        rd_chk("be_top_byte", BASE + 32'd20, 32'h11AA5678);
    endtask

    task automatic test_hold_select;
        int acks, ack_cyc, dbus_bad;
        logic [31:0] data;
        acks = 0; ack_cyc = -1; dbus_bad = 0; data = '0;
        @(posedge OPB_Clk); #1;
        OPB_ABus = BASE + 32'd8; OPB_RNW = 1'b1; OPB_BE = 4'hF;
        OPB_select = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge OPB_Clk); #1;
            if (Sl_xferAck) begin
                acks++; ack_cyc = i; data = Sl_DBus;
            end else if (Sl_DBus !== 32'd0) dbus_bad++;
        end
        OPB_select = 1'b0;
        @(posedge OPB_Clk); #1;
        compared++;
        if (acks != 1) begin
            mismatched++; $display("FAIL hold_ack_count: got %0d want 1", acks);
        end
        compared++;
        if (ack_cyc != 1) begin
            mismatched++; $display("FAIL hold_latency: got %0d want 1", ack_cyc);
        end
        compared++;
        if (data !== 32'hDEADBEEF) begin
            mismatched++; $display("FAIL hold_data: got %h want deadbeef", data);
        end
        compared++;
        if (dbus_bad != 0) begin
            mismatched++; $display("FAIL hold_dbus_zero: got %0d want 0", dbus_bad);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] rd; logic err;
        bus(UNMAP, 1'b1, 32'd0, 4'hF, rd, err);
        compared++;
        if ({err, rd} !== {1'b1, 32'd0}) begin
            mismatched++;
            $display("FAIL unmapped_read: got err=%b d=%h want 1 0", err, rd);
        end
        bus(UNMAP, 1'b0, 32'hFFFFFFFF, 4'hF, rd, err);
        compared++;
        if (err !== 1'b1) begin
            mismatched++; $display("FAIL unmapped_write_err: got %b want 1", err);
        end
        bus(BASE, 1'b1, 32'd0, 4'hF, rd, err);
        compared++;
        if ({err, rd} !== {1'b0, 32'd0}) begin
            mismatched++;
            $display("FAIL mapped_no_err: got err=%b d=%h want 0 0", err, rd);
        end
        rd_chk("unmapped_no_side_effect", STATUS, 32'h01080001);
    endtask

    task automatic test_auto_commit;
        wr(CTRL, 32'd2, 4'hF);
        compared++;
        if (user_commit !== 1'b0) begin
            mismatched++; $display("FAIL auto_enable_no_commit: got %b want 0", user_commit);
        end
        wr(BASE, 32'h00000011, 4'hF);
        compared++;
        if ({user_load, user_commit, user_data_out[31:0]} !== {8'h21, 1'b1, 32'h11}) begin
            mismatched++;
            $display("FAIL auto_commit: got load=%h commit=%b r0=%h want 21 1 11",
                     user_load, user_commit, user_data_out[31:0]);
        end
        rd_chk("auto_ctrl", CTRL, 32'd2);
        wr(CTRL, 32'd3, 4'hF);
        compared++;
        if ({user_load, user_commit} !== {8'h00, 1'b1}) begin
            mismatched++;
            $display("FAIL commit_nochange: got load=%h commit=%b want 00 1",
                     user_load, user_commit);
        end
        rd_chk("auto_status", STATUS, 32'h01080003);
        wr(CTRL, 32'd0, 4'hF);
        rd_chk("auto_off", CTRL, 32'd0);
    endtask

    task automatic test_reset_mid;
        logic got;
        got = 1'b0;
        @(posedge OPB_Clk); #1;
        OPB_ABus = BASE + 32'd4; OPB_RNW = 1'b0; OPB_DBus = 32'h55;
        OPB_BE = 4'hF; OPB_select = 1'b1;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge OPB_Clk); #1;
            if (Sl_xferAck) got = 1'b1;
        end
        OPB_Rst = 1'b1;
        @(posedge OPB_Clk); #1;
        compared++;
        if ({Sl_xferAck, Sl_errAck, Sl_DBus, user_load, user_commit, user_data_out} !== 299'd0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: got ack=%b load=%h want all 0",
                     Sl_xferAck, user_load);
        end
        OPB_select = 1'b0; OPB_Rst = 1'b0;
        rd_chk("reset_mid_write_dropped", BASE + 32'd4, 32'd0);
        rd_chk("reset_mid_reg2", BASE + 32'd8, 32'd0);
        rd_chk("reset_mid_status", STATUS, 32'h01080000);
    endtask

    task automatic test_wrap;
        force dut.commit_count = 16'hFFFE;
        @(posedge OPB_Clk); #1;
        release dut.commit_count;
        wr(CTRL, 32'd1, 4'hF);
        rd_chk("wrap_ffff", STATUS, 32'h0108FFFF);
        wr(CTRL, 32'd1, 4'hF);
        rd_chk("wrap_zero", STATUS, 32'h01080000);
    endtask

    initial begin
        test_reset();
        test_double_buffer();
        test_byte_enable();
        test_hold_select();
        test_unmapped();
        test_auto_commit();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
